// File: rtl/neg18_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : neg18_pkg                                                          |
// | Desc   : Shared types and constants for the NEG/SUB/CMP/ABS sequencer.     |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
package neg18_pkg;

  localparam int WIDTH = 18;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    OP_NEG = 2'b00,
    OP_SUB = 2'b01,
    OP_CMP = 2'b10,
    OP_ABS = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INV  = 3'd1,
    INC  = 3'd2,
    ADD  = 3'd3,
    RESP = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    STEP_INV = 2'd0,
    STEP_INC = 2'd1,
    STEP_ADD = 2'd2
  } step_t;

endpackage
`default_nettype wire

// File: rtl/neg18_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : neg18_sequencer_if                                                 |
// | Desc   : Request/response handshake bundle between issue logic and the     |
// |          sequencer.                                                        |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
interface neg18_sequencer_if #(
  parameter int WIDTH = 18
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_z;
  logic             rsp_n;
  logic             rsp_c;
  logic             rsp_v;
  logic             busy;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_z, rsp_n, rsp_c, rsp_v, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_z, rsp_n, rsp_c, rsp_v, busy
  );
endinterface
`default_nettype wire

// File: rtl/neg18_sequencer_twos_step18.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : twos_step18                                                        |
// | Desc   : One combinational datapath step: invert, increment, or add with   |
// |          carry-in of one.                                                   |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
module twos_step18
  import neg18_pkg::*;
#(
  parameter int WIDTH = neg18_pkg::WIDTH
) (
  input  step_t            i_step,
  input  logic [WIDTH-1:0] i_w,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_operand,
  output logic [WIDTH-1:0] o_w_next,
  output logic             o_carry
);

  logic [WIDTH:0] w_sum;

  always_comb begin
    w_sum = '0;
    case (i_step)
      STEP_INV: w_sum = {1'b0, ~i_operand};
      STEP_INC: w_sum = {1'b0, i_w} + (WIDTH+1)'(1);
      STEP_ADD: w_sum = {1'b0, i_a} + {1'b0, i_w} + (WIDTH+1)'(1);
      default:  w_sum = '0;
    endcase
  end

  assign o_w_next = w_sum[WIDTH-1:0];
  assign o_carry  = w_sum[WIDTH];

endmodule
`default_nettype wire

// File: rtl/neg18_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : neg18_sequencer                                                    |
// | Desc   : Multi-cycle NEG/SUB/CMP/ABS controller over a shared work register|
// |          with valid/ready request and backpressured response.              |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
module neg18_sequencer
  import neg18_pkg::*;
#(
  parameter int WIDTH = neg18_pkg::WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  neg18_sequencer_if.slave    bus
);

  localparam int              MSB       = WIDTH - 1;
  localparam logic [WIDTH-1:0] c_min_neg = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           r_state;
  op_t              r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_w;
  logic [WIDTH-1:0] r_result;
  logic             r_rsp_valid;
  logic             r_z;
  logic             r_n;
  logic             r_c;
  logic             r_v;

  step_t            w_step;
  logic             w_neg_like;
  logic [WIDTH-1:0] w_operand;
  logic [WIDTH-1:0] w_next;
  logic             w_carry;
  logic             w_v_add;

  // NEG and ABS negate A; SUB and CMP negate B before the add.
  assign w_neg_like = (r_op == OP_NEG) || (r_op == OP_ABS);
  assign w_operand  = w_neg_like ? r_a : r_b;

  always_comb begin
    w_step = STEP_ADD;
    case (r_state)
      INV:     w_step = STEP_INV;
      INC:     w_step = STEP_INC;
      default: w_step = STEP_ADD;
    endcase
  end

  twos_step18 #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_step    (w_step),
    .i_w       (r_w),
    .i_a       (r_a),
    .i_operand (w_operand),
    .o_w_next  (w_next),
    .o_carry   (w_carry)
  );

  assign w_v_add = (r_a[MSB] != r_b[MSB]) && (w_next[MSB] != r_a[MSB]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_op        <= OP_NEG;
      r_a         <= '0;
      r_b         <= '0;
      r_w         <= '0;
      r_result    <= '0;
      r_rsp_valid <= 1'b0;
      r_z         <= 1'b0;
      r_n         <= 1'b0;
      r_c         <= 1'b0;
      r_v         <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_op <= op_t'(bus.req_op);
            r_a  <= bus.req_a;
            r_b  <= bus.req_b;
            // Non-negative ABS is already its own answer.
            if ((op_t'(bus.req_op) == OP_ABS) && !bus.req_a[MSB]) begin
              r_w         <= bus.req_a;
              r_result    <= bus.req_a;
              r_z         <= (bus.req_a == '0);
              r_n         <= bus.req_a[MSB];
              r_c         <= 1'b0;
              r_v         <= 1'b0;
              r_rsp_valid <= 1'b1;
              r_state     <= RESP;
            end else begin
              r_state <= INV;
            end
          end
        end
        INV: begin
          r_w     <= w_next;
          r_state <= w_neg_like ? INC : ADD;
        end
        INC: begin
          r_w         <= w_next;
          r_result    <= w_next;
          r_z         <= (w_next == '0);
          r_n         <= w_next[MSB];
          r_c         <= w_carry;
          r_v         <= (r_a == c_min_neg);
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        ADD: begin
          r_w         <= w_next;
          // CMP reports A unchanged; flags still come from the difference.
          r_result    <= (r_op == OP_CMP) ? r_a : w_next;
          r_z         <= (w_next == '0);
          r_n         <= w_next[MSB];
          r_c         <= w_carry;
          r_v         <= w_v_add;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.busy       = (r_state != IDLE);
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_result = r_result;
  assign bus.rsp_z      = r_z;
  assign bus.rsp_n      = r_n;
  assign bus.rsp_c      = r_c;
  assign bus.rsp_v      = r_v;

endmodule
`default_nettype wire

// File: tb/tb_neg18_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_neg18_sequencer                                                 |
// | Desc   : Vector table, corner sequences and randomized ops vs a reference. |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
module tb_neg18_sequencer;
  import neg18_pkg::*;

  typedef struct {
    logic [17:0] result;
    logic        z, n, c, v;
    int          lat;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [17:0] a, b, result;
    logic        z, n, c, v;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs[12];

  neg18_sequencer_if #(.WIDTH(18)) bus ();

  neg18_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic over 2^18.
  function automatic exp_t model(input logic [1:0] op, input logic [17:0] a, input logic [17:0] b);
    exp_t e;
    int ua, ub, sa, sb, d, sd;
    ua = int'(a);
    ub = int'(b);
    sa = a[17] ? ua - 262144 : ua;
    sb = b[17] ? ub - 262144 : ub;
    e.lat = 3;
    e.c = 1'b0;
    e.v = 1'b0;
    d = 0;
    case (op)
      OP_NEG: begin
        d = (262144 - ua) % 262144;
        e.result = 18'(d);
        e.c = (ua == 0);
        e.v = (sa == -131072);
      end
      OP_SUB, OP_CMP: begin
        d  = (ua - ub + 262144) % 262144;
        sd = sa - sb;
        e.c = (ua >= ub);
        e.v = (sd > 131071) || (sd < -131072);
        e.result = (op == OP_CMP) ? a : 18'(d);
      end
      default: begin
        if (sa >= 0) begin
          d = ua;
          e.lat = 1;
        end else begin
          d = (262144 - ua) % 262144;
          e.v = (sa == -131072);
        end
        e.result = 18'(d);
      end
    endcase
    e.z = (d == 0);
    e.n = (d >= 131072);
    return e;
  endfunction

  function automatic logic [17:0] pick();
    case ($urandom_range(0, 7))
      0:       return 18'h00000;
      1:       return 18'h20000;
      2:       return 18'h3FFFF;
      3:       return 18'h1FFFF;
      4:       return 18'h00001;
      default: return 18'($urandom);
    endcase
  endfunction

  task automatic run_vec(input string name, input logic [1:0] op, input logic [17:0] a,
                         input logic [17:0] b, input exp_t e, input int hold);
    int lat;
    @(negedge clk);
    check({name, " req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'($urandom);
    bus.req_a     = 18'($urandom);
    bus.req_b     = 18'($urandom);
    lat = 1;
    @(negedge clk);
    while (!bus.rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'(e.lat));
    check({name, " result"}, 32'(bus.rsp_result), 32'(e.result));
    check({name, " zncv"}, 32'({bus.rsp_z, bus.rsp_n, bus.rsp_c, bus.rsp_v}),
          32'({e.z, e.n, e.c, e.v}));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, " hold valid"}, 32'(bus.rsp_valid), 32'd1);
      check({name, " hold result"}, 32'(bus.rsp_result), 32'(e.result));
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    check({name, " rsp_valid drop"}, 32'(bus.rsp_valid), 32'd0);
    check({name, " req_ready back"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    exp_t e;
    logic [1:0]  op;
    logic [17:0] a, b;

    vecs[0]  = '{OP_SUB, 18'h00005, 18'h00003, 18'h00002, 1'b0, 1'b0, 1'b1, 1'b0, 3};
    vecs[1]  = '{OP_NEG, 18'h00001, 18'h00000, 18'h3FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 3};
    vecs[2]  = '{OP_NEG, 18'h00000, 18'h00000, 18'h00000, 1'b1, 1'b0, 1'b1, 1'b0, 3};
    vecs[3]  = '{OP_NEG, 18'h20000, 18'h00000, 18'h20000, 1'b0, 1'b1, 1'b0, 1'b1, 3};
    vecs[4]  = '{OP_CMP, 18'h00003, 18'h00005, 18'h00003, 1'b0, 1'b1, 1'b0, 1'b0, 3};
    vecs[5]  = '{OP_CMP, 18'h1FFFF, 18'h3FFFF, 18'h1FFFF, 1'b0, 1'b1, 1'b0, 1'b1, 3};
    vecs[6]  = '{OP_ABS, 18'h3FFFB, 18'h00000, 18'h00005, 1'b0, 1'b0, 1'b0, 1'b0, 3};
    vecs[7]  = '{OP_ABS, 18'h00007, 18'h00000, 18'h00007, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[8]  = '{OP_SUB, 18'h00007, 18'h00000, 18'h00007, 1'b0, 1'b0, 1'b1, 1'b0, 3};
    vecs[9]  = '{OP_ABS, 18'h20000, 18'h00000, 18'h20000, 1'b0, 1'b1, 1'b0, 1'b1, 3};
    vecs[10] = '{OP_ABS, 18'h00000, 18'h00000, 18'h00000, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vecs[11] = '{OP_SUB, 18'h20000, 18'h00001, 18'h1FFFF, 1'b0, 1'b0, 1'b1, 1'b1, 3};

    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset req_ready", 32'(bus.req_ready), 32'd1);
    check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset result", 32'(bus.rsp_result), 32'd0);
    check("reset flags", 32'({bus.rsp_z, bus.rsp_n, bus.rsp_c, bus.rsp_v}), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      e.result = vecs[i].result;
      e.z = vecs[i].z;
      e.n = vecs[i].n;
      e.c = vecs[i].c;
      e.v = vecs[i].v;
      e.lat = vecs[i].lat;
      run_vec($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, e, i % 2);
    end

    // Backpressure: response held 4 cycles, stray request must be ignored.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = OP_SUB;
    bus.req_a     = 18'd9;
    bus.req_b     = 18'd4;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("bp first valid", 32'(bus.rsp_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        bus.req_valid = 1'b1;
        bus.req_op    = OP_NEG;
        bus.req_a     = 18'd1;
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
      check("bp valid", 32'(bus.rsp_valid), 32'd1);
      check("bp result", 32'(bus.rsp_result), 32'd5);
      check("bp flags", 32'({bus.rsp_z, bus.rsp_n, bus.rsp_c, bus.rsp_v}), 32'b0010);
      check("bp req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp no stray rsp", 32'(bus.rsp_valid), 32'd0);
      check("bp idle", 32'(bus.busy), 32'd0);
    end

    // Asynchronous reset while in INC.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = OP_NEG;
    bus.req_a     = 18'd5;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #2;
    check("rst pre busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rst async busy", 32'(bus.busy), 32'd0);
    check("rst async req_ready", 32'(bus.req_ready), 32'd1);
    check("rst async result", 32'(bus.rsp_result), 32'd0);
    check("rst async valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst no rsp", 32'(bus.rsp_valid), 32'd0);
    end
    e = model(OP_NEG, 18'd2, 18'd0);
    check("rst follow model", 32'(e.result), 32'h3FFFE);
    run_vec("post-rst neg2", OP_NEG, 18'd2, 18'd0, e, 0);

    for (int i = 0; i < 150; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = pick();
      b  = pick();
      e  = model(op, a, b);
      run_vec($sformatf("rnd%0d op%0d a=%h b=%h", i, op, a, b), op, a, b, e,
              int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
